// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK sliding-window generator.
// Pixels arrive one per pix_valid cycle in raster order. K-1 line buffers
// hold the previous lines, and a KxK shift array builds the window. A window
// is flagged valid only when every pixel in it belongs to the current frame.
// Output is the window whose bottom-right pixel is the qualifying input,
// registered one cycle after that input.

module conv_window_gen #(
   parameter  int DW    = 8,
   parameter  int K     = 3,
   parameter  int IMG_W = 640,
   parameter  int IMG_H = 480,
   localparam int CW    = $clog2(IMG_W),
   localparam int RW    = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     pix_in,
   input  logic              pix_valid,
   input  logic              sof,
   output logic [K*K*DW-1:0] win_out,
   output logic              win_valid,
   output logic [RW-1:0]     win_row,
   output logic [CW-1:0]     win_col,
   output logic              frame_done
);

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

   // ------------------------------------------------------------------
   // Position counters: col_q/row_q give the coordinates the next pixel
   // will take unless it carries sof.
   // ------------------------------------------------------------------
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;

   // Resolve this pixel's coordinates (sof forces 0,0) and the next position.
   always_comb begin
      cur_col = sof ? '0 : col_q;
      cur_row = sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (pix_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
      end
   end

   // Position counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // ------------------------------------------------------------------
   // Line buffers. Buffer j holds line (row-1-j) at each column. Reads are
   // asynchronous so the old contents at cur_col feed the window in the
   // same cycle the new value is written (read-before-write).
   // Contents are never reset: the row counter gating win_valid guarantees
   // that every row in a flagged window was written in the current frame.
   // ------------------------------------------------------------------
   logic [DW-1:0] lb_rd   [K-1];
   logic [DW-1:0] lb_wr   [K-1];
   logic [DW-1:0] vert_col[K];

   for (genvar gi = 0; gi < K - 1; gi++) begin : g_lbuf
      logic [DW-1:0] mem [IMG_W];

      assign lb_rd[gi] = mem[cur_col];

      if (gi == 0) begin : g_head
         assign lb_wr[gi] = pix_in;
      end else begin : g_chain
         assign lb_wr[gi] = lb_rd[gi-1];
      end

      // Shift the vertical column one line down the buffer chain.
      always_ff @(posedge clk) begin
         if (pix_valid) begin
            mem[cur_col] <= lb_wr[gi];
         end
      end
   end

   // Vertical column, top (oldest line) to bottom (current pixel).
   for (genvar gi = 0; gi < K - 1; gi++) begin : g_vcol
      assign vert_col[gi] = lb_rd[K-2-gi];
   end
   assign vert_col[K-1] = pix_in;

   // ------------------------------------------------------------------
   // KxK window shift array, indexed [row][col], col 0 = oldest column.
   // ------------------------------------------------------------------
   logic [DW-1:0] win_q [K][K];
   logic [DW-1:0] win_d [K][K];

   // Shift columns left and insert the new vertical column on each pixel.
   always_comb begin
      win_d = win_q;
      if (pix_valid) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = vert_col[r];
         end
      end
   end

   // Window shift array registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         win_q <= win_d;
      end
   end

   // Flatten the post-shift window: element (r,c) at DW*(r*K+c).
   logic [K*K*DW-1:0] win_flat;

   for (genvar gi = 0; gi < K * K; gi++) begin : g_flat
      assign win_flat[DW*gi +: DW] = win_d[gi / K][gi % K];
   end

   // ------------------------------------------------------------------
   // Output stage. The window is fully inside the frame only once K-1
   // complete lines precede it and K pixels of the current line are in.
   // ------------------------------------------------------------------
   logic              win_hit;
   logic [K*K*DW-1:0] win_out_q, win_out_d;
   logic              win_valid_q, win_valid_d;
   logic [RW-1:0]     win_row_q, win_row_d;
   logic [CW-1:0]     win_col_q, win_col_d;
   logic              frame_done_q, frame_done_d;

   // Decide validity and hold the previous window while nothing qualifies.
   always_comb begin
      win_hit      = pix_valid && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
      win_valid_d  = win_hit;
      win_out_d    = win_hit ? win_flat : win_out_q;
      win_row_d    = win_hit ? cur_row  : win_row_q;
      win_col_d    = win_hit ? cur_col  : win_col_q;
      frame_done_d = win_hit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_out_q    <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         win_out_q    <= win_out_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign win_out    = win_out_q;
   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen on a 4x4 frame with a 3x3 window.
// Expected windows come from a vector table or from a frame-image model,
// are queued when the qualifying pixel is driven and compared when the
// design flags a window.

module tb_conv_window_gen;

   localparam int DW = 8;
   localparam int K  = 3;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int WB = K * K * DW;

   logic          clk;
   logic          rst;
   logic [DW-1:0] pix_in;
   logic          pix_valid;
   logic          sof;
   logic [WB-1:0] win_out;
   logic          win_valid;
   logic [1:0]    win_row;
   logic [1:0]    win_col;
   logic          frame_done;

   conv_window_gen #(.DW(DW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .sof        (sof),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [WB-1:0] win;
      int            row;
      int            col;
      bit            fd;
   } exp_t;

   typedef struct {
      int   pix_idx;
      exp_t e;
   } vec_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_win    = 0;
   int   n_fd     = 0;

   int   m_row = 0;
   int   m_col = 0;
   int   img[H][W];

   logic [WB-1:0] prev_win = '0;

   function automatic logic [WB-1:0] pack9(int a0, int a1, int a2, int a3, int a4,
                                          int a5, int a6, int a7, int a8);
      int            e[9];
      logic [WB-1:0] w;
      e = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      w = '0;
      for (int i = 0; i < 9; i++) w[DW*i +: DW] = e[i][DW-1:0];
      return w;
   endfunction

   function automatic exp_t mk_exp(logic [WB-1:0] w, int r, int c, bit fd);
      exp_t x;
      x.win = w;
      x.row = r;
      x.col = c;
      x.fd  = fd;
      return x;
   endfunction

   task automatic chk(string name, logic [WB-1:0] act, logic [WB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one pixel; optionally let the frame model predict its window.
   task automatic send(int v, bit s, bit use_model);
      exp_t x;
      if (s) begin
         m_row = 0;
         m_col = 0;
      end
      img[m_row][m_col] = v;
      if (use_model && m_row >= K - 1 && m_col >= K - 1) begin
         x.win = '0;
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               x.win[DW*(r*K+c) +: DW] = DW'(img[m_row-K+1+r][m_col-K+1+c]);
         x.row = m_row;
         x.col = m_col;
         x.fd  = (m_row == H - 1) && (m_col == W - 1);
         sb_q.push_back(x);
      end
      pix_in    = v[DW-1:0];
      sof       = s;
      pix_valid = 1'b1;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      m_col++;
      if (m_col == W) begin
         m_col = 0;
         m_row++;
         if (m_row == H) m_row = 0;
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait (bounded) for every queued window to be seen.
   task automatic drain(string name);
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) idle(1);
      idle(1);
      chk({name, "_pending"}, WB'(sb_q.size()), '0);
      sb_q.delete();
   endtask

   // Monitor: compare flagged windows against the scoreboard, and check
   // that outputs hold and frame_done stays low between windows.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_win = win_out;
      end else if (win_valid) begin
         n_win++;
         if (frame_done) n_fd++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_window: got row %0d col %0d win %h, expected none",
                     win_row, win_col, win_out);
         end else begin
            e = sb_q.pop_front();
            $display("window row %0d col %0d fd %0d win %h", win_row, win_col, frame_done, win_out);
            chk("win_out", win_out, e.win);
            chk("win_row", WB'(win_row), WB'(e.row));
            chk("win_col", WB'(win_col), WB'(e.col));
            chk("frame_done", WB'(frame_done), WB'(e.fd));
         end
         prev_win = win_out;
      end else begin
         chk("win_out_hold", win_out, prev_win);
         chk("frame_done_idle", WB'(frame_done), '0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   vec_t tbl[4];
   int   w0;
   int   f0;
   int   ti;

   initial begin
      rst       = 1'b1;
      pix_in    = '0;
      pix_valid = 1'b0;
      sof       = 1'b0;

      tbl[0].pix_idx = 10; tbl[0].e = mk_exp(pack9(0, 1, 2, 4, 5, 6, 8, 9, 10),     2, 2, 1'b0);
      tbl[1].pix_idx = 11; tbl[1].e = mk_exp(pack9(1, 2, 3, 5, 6, 7, 9, 10, 11),    2, 3, 1'b0);
      tbl[2].pix_idx = 14; tbl[2].e = mk_exp(pack9(4, 5, 6, 8, 9, 10, 12, 13, 14),  3, 2, 1'b0);
      tbl[3].pix_idx = 15; tbl[3].e = mk_exp(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15), 3, 3, 1'b1);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_win_out",    win_out, '0);
      chk("rst_win_valid",  WB'(win_valid), '0);
      chk("rst_win_row",    WB'(win_row), '0);
      chk("rst_win_col",    WB'(win_col), '0);
      chk("rst_frame_done", WB'(frame_done), '0);
      rst = 1'b0;
      idle(2);

      // Table-driven frame: pixels 0..15, continuous.
      w0 = n_win; f0 = n_fd; ti = 0;
      for (int i = 0; i < W * H; i++) begin
         if (ti < 4 && tbl[ti].pix_idx == i) begin
            sb_q.push_back(tbl[ti].e);
            ti++;
         end
         send(i, i == 0, 1'b0);
      end
      drain("t1");
      chk("t1_windows", WB'(n_win - w0), WB'(4));
      chk("t1_frame_done", WB'(n_fd - f0), WB'(1));

      // Same frame with random idle gaps and an unqualified sof pulse.
      w0 = n_win; f0 = n_fd;
      for (int i = 0; i < W * H; i++) begin
         send(i, i == 0, 1'b1);
         if (i == 5) begin
            sof = 1'b1;
            idle(1);
            sof = 1'b0;
         end
         idle($urandom_range(0, 3));
      end
      drain("t2");
      chk("t2_windows", WB'(n_win - w0), WB'(4));
      chk("t2_frame_done", WB'(n_fd - f0), WB'(1));

      // Two back-to-back frames, second offset by 100.
      w0 = n_win; f0 = n_fd;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < W * H; i++)
            send(i + 100 * f, i == 0, 1'b1);
      drain("t3");
      chk("t3_windows", WB'(n_win - w0), WB'(8));
      chk("t3_frame_done", WB'(n_fd - f0), WB'(2));

      // sof on pixel 6 aborts the frame; the new frame must use new data only.
      w0 = n_win; f0 = n_fd;
      for (int i = 0; i < 6; i++) send(200 + i, i == 0, 1'b1);
      for (int i = 0; i < W * H; i++) send(50 + i, i == 0, 1'b1);
      drain("t4");
      chk("t4_windows", WB'(n_win - w0), WB'(4));
      chk("t4_frame_done", WB'(n_fd - f0), WB'(1));

      // Asynchronous reset after pixel 12, then a clean frame.
      for (int i = 0; i < 13; i++) send(30 + i, i == 0, 1'b1);
      idle(1);
      chk("t5_pending_before_rst", WB'(sb_q.size()), '0);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_win_out",    win_out, '0);
      chk("t5_rst_win_valid",  WB'(win_valid), '0);
      chk("t5_rst_win_row",    WB'(win_row), '0);
      chk("t5_rst_win_col",    WB'(win_col), '0);
      chk("t5_rst_frame_done", WB'(frame_done), '0);
      sb_q.delete();
      m_row = 0;
      m_col = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      w0 = n_win; f0 = n_fd;
      for (int i = 0; i < W * H; i++) send(70 + i, i == 0, 1'b1);
      drain("t5");
      chk("t5_windows", WB'(n_win - w0), WB'(4));
      chk("t5_frame_done", WB'(n_fd - f0), WB'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
